// File: rtl/stream_adder_pkg.sv
// Shared widths, defaults and state encoding for the stream adder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stream_adder_pkg;

    // AXI-Stream sideband and payload widths of the client interface
    localparam int AXIS_DESTW     = 2;
    localparam int AXIS_USERW     = 2;
    localparam int AXIS_IDW       = 2;
    localparam int AXIS_STRBW     = 8;
    localparam int AXIS_KEEPW     = 8;
    localparam int AXIS_MAX_DATAW = 64;

    // Adder defaults: operand width, counter width and the node address
    localparam int                  ADDER_DATAW = 64;
    localparam int                  ADDER_CNTW  = 16;
    localparam logic [AXIS_DESTW-1:0] ADDER_ADDR = '0;

    // Accumulate while collecting a packet, then hold the result for the consumer
    typedef enum logic {
        ADDER_ACCUM  = 1'b0,
        ADDER_RESULT = 1'b1
    } adder_state_t;

endpackage

// File: rtl/stream_adder.sv
// Sums unsigned operands of one AXIS packet (one per beat) and presents sum/count/overflow/source.
// Latency: tlast beat accepted in cycle N -> result_valid in cycle N+1; one bubble minimum between packets.
// Backpressure: tready drops while a result waits; misrouted beats are always accepted and dropped.
module stream_adder
    import stream_adder_pkg::*;
#(
    parameter int                    DATAW   = ADDER_DATAW,
    parameter int                    CNTW    = ADDER_CNTW,
    parameter logic [AXIS_DESTW-1:0] MY_ADDR = ADDER_ADDR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      axis_adder_interface_tvalid,
    input  logic                      axis_adder_interface_tlast,
    input  logic [AXIS_DESTW-1:0]     axis_adder_interface_tdest,
    input  logic [AXIS_USERW-1:0]     axis_adder_interface_tuser,
    input  logic [AXIS_IDW-1:0]       axis_adder_interface_tid,
    input  logic [AXIS_STRBW-1:0]     axis_adder_interface_tstrb,
    input  logic [AXIS_KEEPW-1:0]     axis_adder_interface_tkeep,
    input  logic [AXIS_MAX_DATAW-1:0] axis_adder_interface_tdata,
    output logic                      axis_adder_interface_tready,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [DATAW-1:0]          result_sum,
    output logic [CNTW-1:0]           result_count,
    output logic                      result_overflow,
    output logic [AXIS_USERW-1:0]     result_src,
    output logic [CNTW-1:0]           drop_count
);

    adder_state_t          state;
    logic [DATAW-1:0]      sum_q;
    logic [CNTW-1:0]       count_q;
    logic                  overflow_q;
    logic [AXIS_USERW-1:0] src_q;
    logic                  first_seen_q;
    logic [CNTW-1:0]       drop_q;

    logic                  accept;
    logic                  match;
    logic [DATAW:0]        sum_next;

    // Sideband fields this sink does not interpret
    logic                  unused_sideband;
    assign unused_sideband = ^{axis_adder_interface_tid,
                               axis_adder_interface_tstrb,
                               axis_adder_interface_tkeep,
                               axis_adder_interface_tdata[AXIS_MAX_DATAW-1:DATAW]};

    // Ready depends only on state (and reset), never on tvalid
    assign axis_adder_interface_tready = (state == ADDER_ACCUM) && !rst;
    assign accept   = axis_adder_interface_tvalid && axis_adder_interface_tready;
    assign match    = (axis_adder_interface_tdest == MY_ADDR);
    // One extra bit captures the carry out of the operand width
    assign sum_next = {1'b0, sum_q} + {1'b0, axis_adder_interface_tdata[DATAW-1:0]};

    // Packet accumulation, drop accounting and result hand-off
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ADDER_ACCUM;
            sum_q        <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            src_q        <= '0;
            first_seen_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            case (state)
                ADDER_ACCUM: begin
                    if (accept && match) begin
                        sum_q      <= sum_next[DATAW-1:0];
                        overflow_q <= overflow_q | sum_next[DATAW];
                        if (count_q != '1) begin
                            count_q <= count_q + 1'b1;
                        end
                        if (!first_seen_q) begin
                            src_q        <= axis_adder_interface_tuser;
                            first_seen_q <= 1'b1;
                        end
                        if (axis_adder_interface_tlast) begin
                            state <= ADDER_RESULT;
                        end
                    end else if (accept) begin
                        // Misrouted beat: swallowed so the stream keeps moving; its tlast is ignored
                        if (drop_q != '1) begin
                            drop_q <= drop_q + 1'b1;
                        end
                    end
                end
                ADDER_RESULT: begin
                    if (result_ready) begin
                        sum_q        <= '0;
                        count_q      <= '0;
                        overflow_q   <= 1'b0;
                        first_seen_q <= 1'b0;
                        state        <= ADDER_ACCUM;
                    end
                end
                default: state <= ADDER_ACCUM;
            endcase
        end
    end

    // Results come straight from the accumulators; only meaningful while result_valid is high
    assign result_valid    = (state == ADDER_RESULT);
    assign result_sum      = sum_q;
    assign result_count    = count_q;
    assign result_overflow = overflow_q;
    assign result_src      = src_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_stream_adder.sv
// Directed bench for stream_adder: packet sums, overflow, backpressure, misroute drops, reset.
// Latency: checks result_valid one cycle after the tlast beat.
// Backpressure: holds result_ready low to check tready and result stability.
module tb_stream_adder;
    import stream_adder_pkg::*;

    localparam int DATAW = 64;
    localparam int CNTW  = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      tvalid;
    logic                      tlast;
    logic [AXIS_DESTW-1:0]     tdest;
    logic [AXIS_USERW-1:0]     tuser;
    logic [AXIS_IDW-1:0]       tid;
    logic [AXIS_STRBW-1:0]     tstrb;
    logic [AXIS_KEEPW-1:0]     tkeep;
    logic [AXIS_MAX_DATAW-1:0] tdata;
    logic                      tready;
    logic                      result_valid;
    logic                      result_ready;
    logic [DATAW-1:0]          result_sum;
    logic [CNTW-1:0]           result_count;
    logic                      result_overflow;
    logic [AXIS_USERW-1:0]     result_src;
    logic [CNTW-1:0]           drop_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_adder #(.DATAW(DATAW), .CNTW(CNTW), .MY_ADDR(2'b00)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .axis_adder_interface_tvalid (tvalid),
        .axis_adder_interface_tlast  (tlast),
        .axis_adder_interface_tdest  (tdest),
        .axis_adder_interface_tuser  (tuser),
        .axis_adder_interface_tid    (tid),
        .axis_adder_interface_tstrb  (tstrb),
        .axis_adder_interface_tkeep  (tkeep),
        .axis_adder_interface_tdata  (tdata),
        .axis_adder_interface_tready (tready),
        .result_valid                (result_valid),
        .result_ready                (result_ready),
        .result_sum                  (result_sum),
        .result_count                (result_count),
        .result_overflow             (result_overflow),
        .result_src                  (result_src),
        .drop_count                  (drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat at a negedge, wait (bounded) for tready, return #1 after the accepting edge
    task automatic beat(input logic [63:0] d, input logic [1:0] dest, input logic [1:0] user,
                        input logic last);
        int n;
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = d;
        tdest  = dest;
        tuser  = user;
        tlast  = last;
        n = 0;
        while (!tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            miscompares++;
            $error("FAIL beat_timeout: observed tready=0 expected tready=1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tvalid = 1'b0; tlast = 1'b0; tdest = '0; tuser = '0; tid = '0;
        tstrb = '1; tkeep = '1; tdata = '0; result_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tready", {63'd0, tready}, 64'd0);
        chk("rst_valid", {63'd0, result_valid}, 64'd0);
        chk("rst_drop", {48'd0, drop_count}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", {63'd0, tready}, 64'd1);

        // 5 + 7 + 10 = 22 over three beats
        beat(64'd5, 2'd0, 2'd0, 1'b0);
        beat(64'd7, 2'd0, 2'd0, 1'b0);
        beat(64'd10, 2'd0, 2'd0, 1'b1);
        chk("p1_valid", {63'd0, result_valid}, 64'd1);
        chk("p1_sum", result_sum, 64'd22);
        chk("p1_count", {48'd0, result_count}, 64'd3);
        chk("p1_ovf", {63'd0, result_overflow}, 64'd0);
        chk("p1_tready", {63'd0, tready}, 64'd0);
        @(posedge clk); #1;
        chk("p1_valid_pulse", {63'd0, result_valid}, 64'd0);
        chk("p1_tready_back", {63'd0, tready}, 64'd1);

        // All-ones + 2 wraps to 1 with carry out
        beat(64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 2'd0, 1'b0);
        beat(64'd2, 2'd0, 2'd0, 1'b1);
        chk("p2_sum", result_sum, 64'd1);
        chk("p2_ovf", {63'd0, result_overflow}, 64'd1);
        chk("p2_count", {48'd0, result_count}, 64'd2);
        @(posedge clk); #1;

        // Backpressure: result held with result_ready low and a new beat waiting
        result_ready = 1'b0;
        beat(64'd1, 2'd0, 2'd0, 1'b1);
        tvalid = 1'b1; tdata = 64'd4; tdest = 2'd0; tlast = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_tready", {63'd0, tready}, 64'd0);
            chk("bp_valid", {63'd0, result_valid}, 64'd1);
            chk("bp_sum", result_sum, 64'd1);
            chk("bp_count", {48'd0, result_count}, 64'd1);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_after_hs_valid", {63'd0, result_valid}, 64'd0);
        chk("bp_after_hs_tready", {63'd0, tready}, 64'd1);
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
        chk("p3_valid", {63'd0, result_valid}, 64'd1);
        chk("p3_sum", result_sum, 64'd4);
        chk("p3_count", {48'd0, result_count}, 64'd1);
        @(posedge clk); #1;

        // Misrouted tlast beat is dropped and does not close the packet
        beat(64'd100, 2'd1, 2'd0, 1'b1);
        chk("mis_no_result", {63'd0, result_valid}, 64'd0);
        chk("mis_drop", {48'd0, drop_count}, 64'd1);
        chk("mis_tready", {63'd0, tready}, 64'd1);
        beat(64'd9, 2'd0, 2'd0, 1'b1);
        chk("p4_valid", {63'd0, result_valid}, 64'd1);
        chk("p4_sum", result_sum, 64'd9);
        chk("p4_count", {48'd0, result_count}, 64'd1);
        chk("p4_drop", {48'd0, drop_count}, 64'd1);
        @(posedge clk); #1;

        // Reset mid-packet discards the partial sum and clears drop_count
        beat(64'd3, 2'd0, 2'd0, 1'b0);
        beat(64'd4, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_tready", {63'd0, tready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_drop", {48'd0, drop_count}, 64'd0);
        beat(64'd6, 2'd0, 2'd0, 1'b1);
        chk("p5_sum", result_sum, 64'd6);
        chk("p5_count", {48'd0, result_count}, 64'd1);
        chk("p5_drop", {48'd0, drop_count}, 64'd0);
        @(posedge clk); #1;

        // Source is taken from the first beat of the packet
        beat(64'd1, 2'd0, 2'b11, 1'b0);
        beat(64'd1, 2'd0, 2'b01, 1'b1);
        chk("p6_src", {62'd0, result_src}, 64'd3);
        chk("p6_sum", result_sum, 64'd2);
        @(posedge clk); #1;
        chk("p6_valid_clear", {63'd0, result_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
